fixed_point_div: RTL and testbench

- Iterative signed fixed-point divider; the inverse operation to the team's fixed-point multiplier.
- Same Q-format on both operands and on the result.
- Computes A/B as (A << FRAC_BITS) / B using a restoring shift-subtract loop, one quotient bit per cycle.
- Sits in datapaths that need normalisation or reciprocal scaling; valid/ready input, valid-pulse output.

---
 rtl/fixed_point_div.sv | 166 ++++++++++++++++
 tb/tb_fixed_point_div.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_div.sv
// -----------------------------------------------------------------------------
// fixed_point_div
//   Iterative signed fixed-point divider. Operands and result share one
//   Q-format (WIDTH total bits, FRAC_BITS fractional). The quotient is formed
//   as (|A| << FRAC_BITS) / |B| with a restoring shift-subtract loop, one
//   quotient bit per clock, then signed and saturated in a final cycle.
//
//   Optional build macro: FIXED_POINT_DIV_ROUND_NEAREST_EN
//     undefined : magnitude truncated toward zero, latency N+1 edges
//     defined   : one extra guard-bit iteration, round half away from zero,
//                 latency N+2 edges
//   where N = WIDTH + FRAC_BITS.
//
// Ports
//   CLK             clock
//   RSTN            synchronous active-low reset
//   VALUE_A_IN      signed dividend
//   VALUE_B_IN      signed divisor
//   VALID_IN        operands valid (sampled only while READY_OUT=1)
//   READY_OUT       block can accept operands
//   VALUE_OUT       signed quotient, held until the next result
//   VALID_OUT       one-cycle result strobe
//   DIV_BY_ZERO_OUT divisor was zero; qualifies VALUE_OUT
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | ready; capture operand magnitudes and signs on VALID_IN
// DIV   | one restoring shift-subtract iteration per cycle
// FIX   | apply sign, saturation and divide-by-zero result; strobe VALID_OUT
// -----------------------------------------------------------------------------
module fixed_point_div #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] VALUE_A_IN,
  input  logic [WIDTH-1:0] VALUE_B_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic [WIDTH-1:0] VALUE_OUT,
  output logic             VALID_OUT,
  output logic             DIV_BY_ZERO_OUT
);

  localparam int N = WIDTH + FRAC_BITS;
`ifdef FIXED_POINT_DIV_ROUND_NEAREST_EN
  localparam int ITER = N + 1;
`else
  localparam int ITER = N;
`endif
  localparam int CW = $clog2(ITER + 1);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [N:0]       POS_LIM = (N+1)'((1 << (WIDTH-1)) - 1);
  localparam logic [N:0]       NEG_LIM = (N+1)'(1 << (WIDTH-1));

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t           state;
  logic             res_neg;
  logic             a_neg;
  logic             b_zero;
  logic [WIDTH-1:0] b_mag;
  logic [ITER-1:0]  dvd;
  logic [WIDTH-1:0] rem;
  logic [ITER-1:0]  quo;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nx;
  logic [N:0]       mag;
  logic [WIDTH-1:0] fix_val;

  // Unsigned magnitudes; the most negative input maps to 2^(WIDTH-1).
  assign a_mag_in = VALUE_A_IN[WIDTH-1] ? -VALUE_A_IN : VALUE_A_IN;
  assign b_mag_in = VALUE_B_IN[WIDTH-1] ? -VALUE_B_IN : VALUE_B_IN;

  // The remainder stays below |B| <= 2^(WIDTH-1), so after the shift it is
  // below 2|B| and the difference fits a WIDTH+1 bit signed value: its MSB
  // is the borrow and decides the quotient bit.
  assign rem_sh   = {rem, dvd[ITER-1]};
  assign rem_diff = rem_sh - {1'b0, b_mag};
  assign rem_ge   = ~rem_diff[WIDTH];
  assign rem_nx   = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

`ifdef FIXED_POINT_DIV_ROUND_NEAREST_EN
  // Drop the guard bit and add it back in: round half away from zero.
  assign mag = {1'b0, quo[ITER-1:1]} + {{N{1'b0}}, quo[0]};
`else
  assign mag = {1'b0, quo};
`endif

  always_comb begin
    fix_val = '0;
    if (b_zero) begin
      fix_val = a_neg ? MAX_NEG : MAX_POS;
    end else if (res_neg) begin
      fix_val = (mag > NEG_LIM) ? MAX_NEG : WIDTH'(-mag);
    end else begin
      fix_val = (mag > POS_LIM) ? MAX_POS : mag[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state           <= IDLE;
      res_neg         <= 1'b0;
      a_neg           <= 1'b0;
      b_zero          <= 1'b0;
      b_mag           <= '0;
      dvd             <= '0;
      rem             <= '0;
      quo             <= '0;
      cnt             <= '0;
      READY_OUT       <= 1'b1;
      VALUE_OUT       <= '0;
      VALID_OUT       <= 1'b0;
      DIV_BY_ZERO_OUT <= 1'b0;
    end else begin
      VALID_OUT <= 1'b0;
      case (state)
        IDLE: begin
          if (VALID_IN) begin
            res_neg   <= VALUE_A_IN[WIDTH-1] ^ VALUE_B_IN[WIDTH-1];
            a_neg     <= VALUE_A_IN[WIDTH-1];
            b_zero    <= (VALUE_B_IN == '0);
            b_mag     <= b_mag_in;
            dvd       <= {a_mag_in, {(ITER-WIDTH){1'b0}}};
            rem       <= '0;
            quo       <= '0;
            cnt       <= CW'(ITER - 1);
            READY_OUT <= 1'b0;
            state     <= DIV;
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= {quo[ITER-2:0], rem_ge};
          dvd <= {dvd[ITER-2:0], 1'b0};
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          VALUE_OUT       <= fix_val;
          DIV_BY_ZERO_OUT <= b_zero;
          VALID_OUT       <= 1'b1;
          READY_OUT       <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          READY_OUT <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_div.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_div
//   Scoreboard bench for fixed_point_div at WIDTH=8, FRAC_BITS=3. The driver
//   keeps a cycle-level model of when the block is ready, pushes the expected
//   result of each accepted operand pair, and a monitor pops and compares on
//   every VALID_OUT pulse (value, divide-by-zero flag and latency).
// -----------------------------------------------------------------------------
module tb_fixed_point_div;

  localparam int W = 8;
  localparam int F = 3;
  localparam int N = W + F;
`ifdef FIXED_POINT_DIV_ROUND_NEAREST_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic [W-1:0] VALUE_A_IN = '0;
  logic [W-1:0] VALUE_B_IN = '0;
  logic         VALID_IN = 1'b0;
  logic         READY_OUT;
  logic [W-1:0] VALUE_OUT;
  logic         VALID_OUT;
  logic         DIV_BY_ZERO_OUT;

  fixed_point_div #(.WIDTH(W), .FRAC_BITS(F)) dut (
    .CLK             (CLK),
    .RSTN            (RSTN),
    .VALUE_A_IN      (VALUE_A_IN),
    .VALUE_B_IN      (VALUE_B_IN),
    .VALID_IN        (VALID_IN),
    .READY_OUT       (READY_OUT),
    .VALUE_OUT       (VALUE_OUT),
    .VALID_OUT       (VALID_OUT),
    .DIV_BY_ZERO_OUT (DIV_BY_ZERO_OUT)
  );

  typedef struct {
    logic [W-1:0] val;
    logic         dbz;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   free_at = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: real-number division of Q-format values, rounded as configured.
  function automatic int ref_div(input int a, input int b, output logic dbz);
    int am, bm, q, r;
    dbz = (b == 0);
    if (b == 0) return (a < 0) ? -(1 << (W-1)) : (1 << (W-1)) - 1;
    am = (a < 0) ? -a : a;
    bm = (b < 0) ? -b : b;
`ifdef FIXED_POINT_DIV_ROUND_NEAREST_EN
    q = ((am * (1 << (F+1))) / bm + 1) / 2;
`else
    q = (am * (1 << F)) / bm;
`endif
    if ((a < 0) != (b < 0)) begin
      r = -q;
      if (r < -(1 << (W-1))) r = -(1 << (W-1));
    end else begin
      r = q;
      if (r > (1 << (W-1)) - 1) r = (1 << (W-1)) - 1;
    end
    return r;
  endfunction

  // Monitor: every result pulse must match the oldest outstanding request.
  always @(negedge CLK) begin
    exp_t e;
    if (VALID_OUT === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("value", int'(VALUE_OUT), int'(e.val));
        chk("dbz", int'(DIV_BY_ZERO_OUT), int'(e.dbz));
        chk("latency", cyc - e.acc, LAT);
      end
    end
  end

  // Called at a falling edge: check READY, drive inputs, advance one cycle.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   r;
    logic z;
    chk("ready", int'(READY_OUT), int'(cyc >= free_at));
    VALID_IN   = v;
    VALUE_A_IN = a;
    VALUE_B_IN = b;
    if (v && cyc >= free_at) begin
      r     = ref_div(int'($signed(a)), int'($signed(b)), z);
      e.val = W'(r);
      e.dbz = z;
      e.acc = cyc + 1;
      sbq.push_back(e);
      free_at = cyc + 1 + LAT;
    end
    @(negedge CLK);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (cyc < free_at && guard < 200) begin
      step(1'b0, '0, '0);
      guard++;
    end
    if (guard >= 200) chk("issue_timeout", 1, 0);
    step(1'b1, a, b);
  endtask

  logic [W-1:0] da [10] = '{8'd24, 8'hE8, 8'd24, 8'hE8, 8'd8, 8'd127, 8'h80, 8'h80, 8'hFB, 8'd5};
  logic [W-1:0] db [10] = '{8'd16, 8'd16, 8'hF0, 8'hF0, 8'd24, 8'd1, 8'd1, 8'hF8, 8'd0, 8'd0};

  initial begin
    logic [W-1:0] ra, rb;
    logic         rv;

    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", int'(READY_OUT), 1);
    chk("rst_valid", int'(VALID_OUT), 0);
    chk("rst_value", int'(VALUE_OUT), 0);
    chk("rst_dbz", int'(DIV_BY_ZERO_OUT), 0);
    RSTN = 1'b1;
    free_at = cyc;

    for (int i = 0; i < 10; i++) issue(da[i], db[i]);

    // Abort a divide mid-flight with a one-cycle reset.
    issue(8'd24, 8'd16);
    repeat (4) step(1'b0, '0, '0);
    RSTN = 1'b0;
    VALID_IN = 1'b0;
    sbq.delete();
    @(negedge CLK);
    chk("midrst_ready", int'(READY_OUT), 1);
    chk("midrst_value", int'(VALUE_OUT), 0);
    chk("midrst_valid", int'(VALID_OUT), 0);
    RSTN = 1'b1;
    free_at = cyc;
    repeat (LAT + 3) step(1'b0, '0, '0);

    // VALID_IN held high: one accept per result period, none while busy.
    repeat (3 * (LAT + 1) + 2) step(1'b1, 8'd24, 8'd16);
    repeat (LAT + 2) step(1'b0, '0, '0);
    chk("b2b_drained", sbq.size(), 0);

    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 2) != 0);
      ra = W'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 15));
      step(rv, ra, rb);
    end

    repeat (LAT + 3) step(1'b0, '0, '0);
    chk("drain_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
